cga_mac_ptseq: RTL

Page-table walk sequencer for the CGA MAC. It sits directly downstream of the segment/PCR register stage and consumes the registered PCR_15_0 and SEG_7_0 values. For each logical memory access it does the following: forms the page-table-entry (PTE) address, reads the PTE over a memory handshake, checks the PTE for page-fault and protection violations, writes back the PGU/WIP usage bits when needed, and returns either a 19-bit physical address or a fault code.

---
 rtl/cga_mac_pkg.sv | 48 ++++
 rtl/cga_mac_ptseq_chk.sv | 44 ++++
 rtl/cga_mac_ptseq.sv | 119 +++++++++++
 3 files changed

// File: rtl/cga_mac_pkg.sv
// Shared constants for the CGA MAC page-table walk sequencer: state encoding,
// access/fault encodings, PTE and PCR field positions.
package cga_mac_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    CHK   = 3'd2,
    WR    = 3'd3,
    DONE  = 3'd4,
    FAULT = 3'd5
  } state_t;

  localparam logic [1:0] ACC_READ  = 2'b00;
  localparam logic [1:0] ACC_WRITE = 2'b01;
  localparam logic [1:0] ACC_FETCH = 2'b10;

  localparam logic [1:0] FLT_NONE = 2'b00;
  localparam logic [1:0] FLT_PAGE = 2'b01;
  localparam logic [1:0] FLT_PROT = 2'b10;

  // Outcome class of a PTE check
  localparam logic [1:0] CLS_DONE  = 2'd0;
  localparam logic [1:0] CLS_WR    = 2'd1;
  localparam logic [1:0] CLS_FAULT = 2'd2;

  localparam int PTE_WPM     = 15;
  localparam int PTE_RPM     = 14;
  localparam int PTE_FPM     = 13;
  localparam int PTE_WIP     = 12;
  localparam int PTE_PGU     = 11;
  localparam int PTE_RING_HI = 10;
  localparam int PTE_RING_LO = 9;
  localparam int PTE_PPN_HI  = 8;

  localparam int PCR_RING_HI = 1;
  localparam int PCR_RING_LO = 0;

  // Fetches always walk the normal table; data accesses may pick the alternate one.
  function automatic logic [3:0] pt_table(input logic [15:0] pcr, input logic usealt,
                                          input logic [1:0] acc);
    if (usealt && acc != ACC_FETCH)
      return {pcr[12:11], pcr[8:7]};
    else
      return {pcr[14:13], pcr[10:9]};
  endfunction

endpackage

// File: rtl/cga_mac_ptseq_chk.sv
// Combinational PTE evaluation: fault/protection checks, write-back decision
// and the PTE image with usage bits set.
module cga_mac_ptseq_chk
  import cga_mac_pkg::*;
(
  input  logic [15:0] pte,
  input  logic [1:0]  acc,
  input  logic [1:0]  ring,
  output logic [1:0]  cls,
  output logic [1:0]  fltcode,
  output logic [15:0] pte_upd
);

  logic perm_ok;

  always_comb begin
    perm_ok = pte[PTE_RPM];
    if (acc == ACC_WRITE)
      perm_ok = pte[PTE_WPM];
    else if (acc == ACC_FETCH)
      perm_ok = pte[PTE_FPM];

    pte_upd          = pte;
    pte_upd[PTE_PGU] = 1'b1;
    if (acc == ACC_WRITE)
      pte_upd[PTE_WIP] = 1'b1;

    cls     = CLS_DONE;
    fltcode = FLT_NONE;
    if (!(pte[PTE_WPM] | pte[PTE_RPM] | pte[PTE_FPM])) begin
      cls     = CLS_FAULT;
      fltcode = FLT_PAGE;
    end else if (ring < pte[PTE_RING_HI:PTE_RING_LO]) begin
      cls     = CLS_FAULT;
      fltcode = FLT_PROT;
    end else if (!perm_ok) begin
      cls     = CLS_FAULT;
      fltcode = FLT_PROT;
    end else if (!pte[PTE_PGU] || (acc == ACC_WRITE && !pte[PTE_WIP])) begin
      cls = CLS_WR;
    end
  end

endmodule

// File: rtl/cga_mac_ptseq.sv
// Page-table walk sequencer: reads the PTE, checks it, writes back usage bits
// when needed and returns the physical address or a fault code.
module cga_mac_ptseq
  import cga_mac_pkg::*;
(
  input  logic        MCLK,
  input  logic        RESETN,
  input  logic        MREQ,
  input  logic [15:0] LA_15_0,
  input  logic [1:0]  ACC_1_0,
  input  logic        USEALT,
  input  logic [15:0] PCR_15_0,
  input  logic [7:0]  SEG_7_0,
  output logic        MACK,
  output logic        MFLT,
  output logic [1:0]  FLTCODE_1_0,
  output logic [18:0] PA_18_0,
  output logic        PTREQ,
  output logic        PTWE,
  output logic [17:0] PTADDR_17_0,
  output logic [15:0] PTDO_15_0,
  input  logic [15:0] PTDI_15_0,
  input  logic        PTACK
);

  state_t      state_reg;
  logic [9:0]  offset_reg;
  logic [1:0]  acc_reg;
  logic [1:0]  ring_reg;
  logic [15:0] pte_reg;

  logic [1:0]  chk_cls;
  logic [1:0]  chk_code;
  logic [15:0] chk_pte;

  cga_mac_ptseq_chk u_chk (
    .pte     (pte_reg),
    .acc     (acc_reg),
    .ring    (ring_reg),
    .cls     (chk_cls),
    .fltcode (chk_code),
    .pte_upd (chk_pte)
  );

  // PTADDR is formed once at acceptance so later PCR/SEG changes cannot leak in.
  always_ff @(posedge MCLK or negedge RESETN) begin
    if (!RESETN) begin
      state_reg   <= IDLE;
      offset_reg  <= '0;
      acc_reg     <= ACC_READ;
      ring_reg    <= '0;
      pte_reg     <= '0;
      MACK        <= 1'b0;
      MFLT        <= 1'b0;
      FLTCODE_1_0 <= FLT_NONE;
      PA_18_0     <= '0;
      PTREQ       <= 1'b0;
      PTWE        <= 1'b0;
      PTADDR_17_0 <= '0;
      PTDO_15_0   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (MREQ) begin
            offset_reg  <= LA_15_0[9:0];
            acc_reg     <= ACC_1_0;
            ring_reg    <= PCR_15_0[PCR_RING_HI:PCR_RING_LO];
            PTADDR_17_0 <= {SEG_7_0, pt_table(PCR_15_0, USEALT, ACC_1_0), LA_15_0[15:10]};
            PTREQ       <= 1'b1;
            PTWE        <= 1'b0;
            state_reg   <= RD;
          end
        end
        RD: begin
          if (PTACK) begin
            pte_reg   <= PTDI_15_0;
            PTREQ     <= 1'b0;
            state_reg <= CHK;
          end
        end
        CHK: begin
          if (chk_cls == CLS_FAULT) begin
            MACK        <= 1'b1;
            MFLT        <= 1'b1;
            FLTCODE_1_0 <= chk_code;
            PA_18_0     <= '0;
            state_reg   <= FAULT;
          end else if (chk_cls == CLS_WR) begin
            PTREQ     <= 1'b1;
            PTWE      <= 1'b1;
            PTDO_15_0 <= chk_pte;
            state_reg <= WR;
          end else begin
            MACK      <= 1'b1;
            PA_18_0   <= {pte_reg[PTE_PPN_HI:0], offset_reg};
            state_reg <= DONE;
          end
        end
        WR: begin
          if (PTACK) begin
            PTREQ     <= 1'b0;
            PTWE      <= 1'b0;
            MACK      <= 1'b1;
            PA_18_0   <= {pte_reg[PTE_PPN_HI:0], offset_reg};
            state_reg <= DONE;
          end
        end
        default: begin
          MACK        <= 1'b0;
          MFLT        <= 1'b0;
          FLTCODE_1_0 <= FLT_NONE;
          PA_18_0     <= '0;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

endmodule
